// File: rtl/sw_event_encoder.sv
// sw_event_encoder
//   Conditions the four raw request switches for the queue-state FSM.
//   Each switch is synchronised, qualified by a minimum hold time, and
//   every qualified release becomes one event. Events are handed to the
//   consumer one at a time over a valid/ready handshake. Higher switch
//   index wins when several events are pending.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sw_in     in   [3] drive(-8), [2] +12, [1] +8, [0] +4; raw async levels
//   ev_ready  in   consumer accepts an event this cycle
//   ev_valid  out  ev_code holds a pending event
//   ev_code   out  index of the event's switch
//   ev_drop   out  one-cycle pulse: at least one event lost
//   drop_cnt  out  saturating count of drop cycles
module sw_event_encoder #(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       ev_drop,
  output logic [7:0] drop_cnt
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES);

  typedef enum logic [1:0] {StIdle, StHeld, StFire} ch_state_e;

  logic [3:0] sync1_q;
  logic [3:0] s_q;
  logic [3:0] fire;

  logic [3:0] pend_q, pend_d;
  logic [3:0] clr;
  logic [3:0] drop_vec;
  logic [1:0] hi_idx;
  logic       load;

  logic       ev_valid_q;
  logic [1:0] ev_code_q;
  logic       ev_drop_q;
  logic [7:0] drop_cnt_q;

  // Two-flop synchroniser per switch.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= sw_in;
      s_q     <= sync1_q;
    end
  end

  // Per-channel hold qualifier.
  for (genvar i = 0; i < 4; i++) begin : g_ch
    ch_state_e       state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (s_q[i]) begin
              state_q <= StHeld;
              cnt_q   <= CntW'(1);
            end
          end
          StHeld: begin
            if (s_q[i]) begin
              if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
            end else if (cnt_q == CntMax) begin
              state_q <= StFire;
            end else begin
              // Released too early: press is discarded.
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StFire: begin
            // Switch level ignored here; a still-high level restarts from idle.
            state_q <= StIdle;
            cnt_q   <= '0;
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign fire[i] = (state_q == StFire);
  end

  // Pending flags and output-slot arbitration.
  always_comb begin
    load = !ev_valid_q || ev_ready;

    hi_idx = 2'd0;
    if (pend_q[3])      hi_idx = 2'd3;
    else if (pend_q[2]) hi_idx = 2'd2;
    else if (pend_q[1]) hi_idx = 2'd1;
    else                hi_idx = 2'd0;

    clr = '0;
    if (load && (|pend_q)) clr = 4'b0001 << hi_idx;

    // A fire onto an occupied flag that is not draining this cycle is lost.
    drop_vec = fire & pend_q & ~clr;
    // Set beats clear on the same bit: the new event stays pending.
    pend_d   = (pend_q & ~clr) | fire;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pend_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 2'd0;
      ev_drop_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      pend_q <= pend_d;
      if (load) begin
        if (|pend_q) begin
          ev_valid_q <= 1'b1;
          ev_code_q  <= hi_idx;
        end else begin
          ev_valid_q <= 1'b0;
        end
      end
      ev_drop_q <= |drop_vec;
      if ((|drop_vec) && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_code  = ev_code_q;
  assign ev_drop  = ev_drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule
